// File: rtl/seg7_disp_arb.sv
// Display-ownership arbiter: grants one of four sources the 32-bit display word,
// enforces a minimum dwell per owner and rotates by round-robin or fixed priority.
module seg7_disp_arb #(
  parameter int unsigned DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [127:0]       req_data,
  input  logic               pri_mode,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic               freeze,
  output logic [3:0]         gnt,
  output logic [1:0]         o_src,
  output logic               o_valid,
  output logic [31:0]        o_data,
  output logic [3:0]         done
);

  typedef enum logic [1:0] {StIdle, StShow, StExpired} state_e;

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [3:0]         gnt_q, gnt_d;
  logic [1:0]         src_q, src_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [31:0]        data_q, data_d;
  logic [3:0]         done_q, done_d;

  logic               do_grant;
  logic [3:0]         cand;
  logic [3:0]         others;
  logic [1:0]         win;

  // Fixed priority: lowest index wins. Round-robin: search from p+1, owner p last.
  function automatic logic [1:0] arb(input logic [3:0] r, input logic mode,
                                     input logic [1:0] p);
    logic [1:0] idx;
    logic       found;
    arb   = 2'd0;
    found = 1'b0;
    if (mode) begin
      for (int i = 3; i >= 0; i--) begin
        if (r[i]) arb = 2'(i);
      end
    end else begin
      for (int i = 1; i <= 4; i++) begin
        idx = p + 2'(i);
        if (r[idx] && !found) begin
          arb   = idx;
          found = 1'b1;
        end
      end
    end
    return arb;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gnt_q   <= '0;
      src_q   <= '0;
      ptr_q   <= 2'd3;
      data_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gnt_d    = gnt_q;
    src_d    = src_q;
    ptr_d    = ptr_q;
    do_grant = 1'b0;
    cand     = '0;
    others   = req & ~gnt_q;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          do_grant = 1'b1;
          cand     = req;
        end
      end
      StShow, StExpired: begin
        if (!req[src_q]) begin
          // Owner released: dwell forfeited and freeze ignored.
          if (|others) begin
            do_grant = 1'b1;
            cand     = others;
          end else begin
            state_d = StIdle;
            gnt_d   = '0;
          end
        end else if (state_q == StShow) begin
          if (!freeze) begin
            cnt_d = cnt_q - DWELL_W'(1);
            if (cnt_q <= DWELL_W'(1)) state_d = StExpired;
          end
        end else if ((|others) && !freeze) begin
          do_grant = 1'b1;
          cand     = others;
        end
      end
      default: state_d = StIdle;
    endcase

    win = arb(cand, pri_mode, ptr_q);
    if (do_grant) begin
      state_d = StShow;
      gnt_d   = 4'b0001 << win;
      src_d   = win;
      ptr_d   = win;
      cnt_d   = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
    end
  end

  always_comb begin
    data_d = data_q;
    if (|gnt_d) data_d = req_data[32*src_d +: 32];
    done_d = gnt_q & ~gnt_d;
  end

  always_comb begin
    gnt     = gnt_q;
    o_src   = src_q;
    o_valid = (state_q != StIdle);
    o_data  = data_q;
    done    = done_q;
  end

endmodule

// File: tb/tb_seg7_disp_arb.sv
// Self-checking bench for seg7_disp_arb: directed scenarios plus random traffic,
// all compared every cycle against an ownership/elapsed-time reference model.
module tb_seg7_disp_arb;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic         pri_mode;
  logic [23:0]  dwell_cycles;
  logic         freeze;
  logic [3:0]   gnt;
  logic [1:0]   o_src;
  logic         o_valid;
  logic [31:0]  o_data;
  logic [3:0]   done;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = none), non-frozen cycles held since grant.
  int          m_owner;
  int          m_ptr;
  int          m_src;
  int          m_hold;
  int          m_deff;
  logic [31:0] m_data;
  logic [3:0]  m_done;

  seg7_disp_arb #(.DWELL_W(24)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_data     (req_data),
    .pri_mode     (pri_mode),
    .dwell_cycles (dwell_cycles),
    .freeze       (freeze),
    .gnt          (gnt),
    .o_src        (o_src),
    .o_valid      (o_valid),
    .o_data       (o_data),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r);
    if (pri_mode) begin
      for (int i = 0; i < 4; i++) if (r[i]) return i;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (r[i]) return i;
      end
    end
    return -1;
  endfunction

  task automatic take(input int w);
    m_owner = w;
    m_ptr   = w;
    m_src   = w;
    m_hold  = 0;
    m_deff  = (dwell_cycles == 0) ? 1 : int'(dwell_cycles);
  endtask

  task automatic model_step();
    int          prev;
    logic [3:0]  others;
    if (rst) begin
      m_owner = -1; m_ptr = 3; m_src = 0; m_hold = 0; m_data = '0; m_done = '0;
      return;
    end
    prev   = m_owner;
    others = req & ~((m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000);
    if (m_owner < 0) begin
      if (req != 0) take(pick(req));
    end else if (!req[m_owner]) begin
      if (others != 0) take(pick(others));
      else m_owner = -1;
    end else if (m_hold >= m_deff && !freeze && others != 0) begin
      take(pick(others));
    end else if (!freeze) begin
      m_hold++;
    end
    m_done = (prev >= 0 && prev != m_owner) ? (4'b0001 << prev) : 4'b0000;
    if (m_owner >= 0) m_data = req_data[32*m_owner +: 32];
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("gnt", {28'b0, gnt}, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    check("o_valid", {31'b0, o_valid}, {31'b0, m_owner >= 0});
    check("o_src", {30'b0, o_src}, 32'(m_src));
    check("o_data", o_data, m_data);
    check("done", {28'b0, done}, {28'b0, m_done});
    check("onehot", {31'b0, ($countones(gnt) > 1)}, 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; freeze = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  function automatic logic [127:0] rnd_data();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  int n;
  int seq_idx [5];
  int seq_t   [5];
  int seq_n;
  int t;
  logic [3:0] last_gnt;

  initial begin
    m_owner = -1; m_ptr = 3; m_src = 0; m_hold = 0; m_deff = 1; m_data = '0; m_done = '0;
    rst = 1'b1; req = '0; req_data = '0; pri_mode = 1'b0; dwell_cycles = 24'd3; freeze = 1'b0;

    // Reset then idle.
    do_reset();
    check("rst_gnt", {28'b0, gnt}, 32'd0);
    check("rst_data", o_data, 32'd0);

    // Single source retained indefinitely, live data view.
    req_data = '0; req_data[95:64] = 32'h1234_5678; req = 4'b0100;
    tick();
    check("single_gnt", {28'b0, gnt}, 32'h4);
    check("single_data", o_data, 32'h1234_5678);
    for (int i = 0; i < 12; i++) tick();
    check("single_hold", {28'b0, gnt}, 32'h4);
    req_data[95:64] = 32'hDEAD_BEEF;
    tick();
    check("single_live", o_data, 32'hDEAD_BEEF);

    // Round-robin fairness: 0,1,2,3,0, three cycles apart.
    do_reset();
    pri_mode = 1'b0; dwell_cycles = 24'd2; req = 4'b1111;
    seq_n = 0; t = 0; last_gnt = '0;
    while (seq_n < 5 && t < 40) begin
      req_data = rnd_data();
      tick(); t++;
      if (gnt != last_gnt && gnt != 0) begin
        seq_idx[seq_n] = int'(o_src); seq_t[seq_n] = t; seq_n++;
      end
      last_gnt = gnt;
    end
    check("rr_count", 32'(seq_n), 32'd5);
    for (int i = 0; i < seq_n; i++) check("rr_order", 32'(seq_idx[i]), 32'(i % 4));
    for (int i = 1; i < seq_n; i++) check("rr_gap", 32'(seq_t[i] - seq_t[i-1]), 32'd3);

    // Fixed priority 1 -> 3 -> 1.
    do_reset();
    pri_mode = 1'b1; req = 4'b1010;
    for (int i = 0; i < 10; i++) begin req_data = rnd_data(); tick(); end

    // Owner drop hands off in one cycle.
    do_reset();
    pri_mode = 1'b1; dwell_cycles = 24'd8; req = 4'b0101;
    tick(); tick(); tick();
    check("drop_pre", {28'b0, gnt}, 32'h1);
    req = 4'b0100;
    tick();
    check("drop_gnt", {28'b0, gnt}, 32'h4);
    check("drop_done", {28'b0, done}, 32'h1);

    // Freeze 5 cycles with dwell 4: handoff 10 cycles after grant.
    do_reset();
    pri_mode = 1'b0; dwell_cycles = 24'd4; req = 4'b0011;
    tick();
    check("frz_first", {28'b0, gnt}, 32'h1);
    n = 0;
    tick(); n++;
    freeze = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); n++; end
    freeze = 1'b0;
    while (gnt != 4'b0010 && n < 40) begin tick(); n++; end
    check("frz_handoff", 32'(n), 32'd10);

    // Dwell zero: handoff every 2 cycles, then mid-run reset.
    do_reset();
    dwell_cycles = 24'd0; req = 4'b0011;
    for (int i = 0; i < 9; i++) begin req_data = rnd_data(); tick(); end
    rst = 1'b1;
    tick();
    check("mrst_gnt", {28'b0, gnt}, 32'd0);
    check("mrst_data", o_data, 32'd0);
    check("mrst_done", {28'b0, done}, 32'd0);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      req_data = rnd_data();
      if ($urandom_range(7) == 0) req = 4'($urandom);
      if ($urandom_range(39) == 0) dwell_cycles = 24'($urandom_range(5));
      if ($urandom_range(49) == 0) pri_mode = ~pri_mode;
      freeze = ($urandom_range(5) == 0);
      rst    = ($urandom_range(199) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_disp_arb.md
# seg7_disp_arb

Display-ownership arbiter for the 8-digit seven-segment driver. Up to four requesters (e.g. PC view, register probe, memory-data probe, debug counter) compete for the single 32-bit display word. The block grants one owner at a time, guarantees each owner a minimum on-screen dwell, and rotates fairly or by fixed priority. Its outputs feed the display driver's data input directly.

## Interface
Parameters:
- `DWELL_W`, 24: width of the dwell counter and `dwell_cycles`.

Ports:
- `clk`  in  1  system clock. The single clock for the block.
- `rst`  in  1  reset. Synchronous, active-high.
- `req`  in  4  request per source; level-sensitive; bit i = source i.
- `req_data`  in  128  source data; bits [32i+31:32i] belong to source i.
- `pri_mode`  in  1  0 = round-robin, 1 = fixed priority (source 0 highest).
- `dwell_cycles`  in  DWELL_W  minimum owner hold time in cycles; a value of 0 is treated as 1.
- `freeze`  in  1  while high, the current owner is held and the dwell counter is paused.
- `gnt`  out  4  one-hot grant; all zero when there is no owner.
- `o_src`  out  2  index of the current or last owner.
- `o_valid`  out  1  high while an owner is granted.
- `o_data`  out  32  display word sent to the driver.
- `done`  out  4  one-cycle pulse on bit i when source i loses its grant.

## Operation
- States:
  - IDLE: no owner.
  - SHOW: owner granted, dwell counter running.
  - EXPIRED: dwell satisfied, owner retained until it is displaced.
- IDLE:
  - If `req` is nonzero, arbitrate, load the counter with max(`dwell_cycles`, 1), set `gnt`/`o_src`/`o_valid`, and go to SHOW.
- SHOW:
  - The counter decrements each cycle unless `freeze` is high.
  - On reaching 0, go to EXPIRED.
- EXPIRED:
  - If any other source requests and `freeze` is low, re-arbitrate among the other sources, grant the winner, reload the counter, and go to SHOW.
- Owner drop (in SHOW or EXPIRED): if the owner's `req` falls, it is released immediately; the dwell is forfeited and `freeze` is ignored.
  - If any other source is requesting, grant it (reload, SHOW).
  - Otherwise go to IDLE.
- Data path:
  - While granted, `o_data` is registered from the owner's `req_data` slice every cycle (live view).
  - In IDLE, `o_data` holds the last value. `o_src` also holds.
- Round-robin:
  - The pointer equals the last granted index.
  - The search starts at pointer+1 mod 4 and wraps from 3 to 0.
- Fixed priority: the lowest requesting index wins.
- Re-arbitration from EXPIRED always excludes the current owner. With no other requester, the owner stays, even in fixed-priority mode.
- `done[i]` pulses in the same cycle that `gnt[i]` deasserts.
- `pri_mode` is sampled only at arbitration instants. A change mid-dwell has no effect on the current owner.
- Reset values: state IDLE, `gnt`=0, `o_valid`=0, `o_src`=0, `o_data`=0, `done`=0, counter=0, RR pointer=3 (so source 0 is searched first).

## Timing
- Request to grant: `req` sampled high at edge t gives `gnt`/`o_valid`/`o_src` at t+1. `o_data` carries that source's data sampled at edge t.
- Data latency while owned: one cycle from `req_data` to `o_data`.
- Dwell: with D = `dwell_cycles` and no freeze, the earliest handoff to a waiting source has the new `gnt` appear D+1 cycles after the old grant rose.
- Owner drop: `req` low at edge t gives `gnt` low and `done` pulse at t+1. If another source is pending, its grant also appears at t+1, with no gap cycle.
- `freeze` asserted for F cycles during SHOW extends the dwell by exactly F cycles.
- `rst` mid-operation: all outputs take their reset values at the next edge. No `done` pulse is generated by reset.
- `gnt` never has more than one bit set.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles with `req`=0 -> `gnt`=0, `o_valid`=0, `o_data`=0 throughout.
- Single source: `req`=4'b0100, slice 2=32'h1234_5678, `dwell_cycles`=3 -> `gnt`=4'b0100 at t+1, `o_data`=32'h1234_5678, owner retained indefinitely; changing slice 2 to 32'hDEAD_BEEF appears on `o_data` one cycle later.
- Round-robin fairness: `req`=4'b1111, `dwell_cycles`=2, `pri_mode`=0 -> grants 0,1,2,3,0 with each handoff 3 cycles apart, and a `done` pulse on each outgoing bit.
- Fixed priority: `pri_mode`=1, `req`=4'b1010 -> source 1 granted first; after dwell, source 3 is granted; after the next dwell, source 1 is granted.
- Owner drop and freeze: owner 0 drops `req` mid-dwell with source 2 pending -> `gnt` goes 4'b0001 to 4'b0100 in one cycle. Separately, `freeze`=1 for 5 cycles with `dwell_cycles`=4 -> handoff delayed to cycle 10 after grant.
- Dwell zero and mid-run reset: `dwell_cycles`=0 with two requesters -> handoff every 2 cycles. Asserting `rst` while granted -> `gnt`=0 and `o_data`=0 next cycle, with no `done` pulse.
